tcu_drl_mul_sched: RTL and testbench
====================================

Name: tcu_drl_mul_sched

Overview:
- Round-robin scheduler that shares one drl shared-multiplier slice between NUM_REQS requesters, e.g. per-lane dot-product feeders.
- Grants the slice per burst; a grant stays locked until the beat marked last is accepted.
- Registers operands into the slice and tracks each beat's tag through a MUL_LATENCY-deep pipeline.
- Returns each product to a single downstream accumulator with requester id, beat index and last flag. The whole pipeline stalls on back-pressure.

Parameters:
- NUM_REQS, 4, number of requesters; must be ≥1.
- MUL_LATENCY, 1, cycles from issue register to a valid mul_y; must be ≥1.
- IDX_W, 4, width of the per-burst beat index.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- req_valid  in  NUM_REQS  beat valid per requester
- req_ready  out  NUM_REQS  beat accepted
- req_last  in  NUM_REQS  final beat of burst
- req_fmt  in  NUM_REQS×4  fmt_s code
- req_a  in  NUM_REQS×16  packed operand A
- req_b  in  NUM_REQS×16  packed operand B
- req_exp_low_larger  in  NUM_REQS  fp8 alignment direction
- req_raw_exp_diff  in  NUM_REQS×7  fp8 exponent difference
- mul_enable  out  1  slice enable; equals issue-stage valid and not stalled
- mul_fmt_s  out  4  to slice
- mul_a  out  16  to slice
- mul_b  out  16  to slice
- mul_exp_low_larger  out  1  to slice
- mul_raw_exp_diff  out  7  to slice
- mul_y  in  25  slice result, valid MUL_LATENCY cycles after issue
- rsp_valid  out  1  result valid
- rsp_ready  in  1  downstream accept
- rsp_y  out  25  product or partial sum
- rsp_id  out  max(1,$clog2(NUM_REQS))  source requester
- rsp_idx  out  IDX_W  beat index within burst
- rsp_last  out  1  last beat of burst
- rsp_err  out  1  illegal fmt

Behaviour:
- Reset (synchronous, reset_n=0): all outputs 0 except rsp_y=0; FSM=IDLE; RR pointer=0; pipeline valids cleared; beat counter=0. In-flight beats are discarded. A reset asserted mid-burst releases the lock.
- stall = rsp_valid & ~rsp_ready. While stall=1:
  - every register holds;
  - mul_enable=0;
  - req_ready=0;
  - mul_* operand outputs stay stable.
- FSM IDLE: pick the first asserted req_valid at or after the RR pointer. Accept its beat in the same cycle (req_ready one-hot, combinational on req_valid and ~stall). Go to LOCKED(owner) unless req_last=1.
- FSM LOCKED: only the owner may receive req_ready. On an accepted owner beat with req_last=1:
  - return to IDLE;
  - RR pointer becomes owner+1, mod NUM_REQS.
  Other requesters wait; a non-owner req_valid is ignored.
- Back-to-back bursts: at most one accept per cycle. A single-beat burst (last on first beat) never enters LOCKED. With one requester continuously valid, throughput is 1 beat/cycle.
- Accept → issue register, next edge. It latches fmt, a, b, exp fields and the tag {id, idx, last, err}. The mul_* outputs are driven from this register.
- idx: beat counter. Cleared at each burst start; +1 per accepted beat; wraps modulo 2^IDX_W; reset to 0 after last.
- Tag pipeline: MUL_LATENCY stages behind the issue register. When the tag reaches the end, mul_y is captured into rsp_y with the tag and rsp_valid=1.
- Total latency, accept→rsp_valid: MUL_LATENCY+1 cycles without stall.
- Legal fmt: 1,2,3,4,9,10,11,12. Any other value:
  - the beat is accepted;
  - mul_enable=0 for that beat;
  - the response emits rsp_y=0, rsp_err=1.
- fmt may differ between beats of a burst; each beat carries its own.
- rsp_valid drops after a handshake unless a new result arrives the same edge. With a full pipe, a handshake and a new arrival occur together for no bubble.

Optional Feature:
TCU_MUL_SCHED_PERF_EN:
- Defined: adds outputs perf_busy_cycles[31:0] (issue-stage valid, not stalled) and perf_stall_cycles[31:0] (stall=1).
- Both counters are cleared by reset, saturate at all-ones, and are free-running otherwise.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Single beat. Setup: NUM_REQS=4, MUL_LATENCY=1, reset.
  - Stimulus: req0 sends a=0x3C00, b=0x4000, fmt=1, last=1.
  - Response: req_ready[0] in the same cycle; rsp_valid 2 cycles later; rsp_y equals the slice output; rsp_id=0, idx=0, last=1, err=0.
- Burst lock. Stimulus: req1 holds a 3-beat burst while req2 stays valid.
  - Response: req2 is not granted until req1's third beat is accepted; rsp_idx=0,1,2 in order; next grant goes to req2.
- Round-robin fairness. Stimulus: all four requesters send continuous single-beat bursts.
  - Response: grant order 0,1,2,3,0… with one accept per cycle.
- Back-pressure. Stimulus: hold rsp_ready=0 for 5 cycles mid-stream.
  - Response: req_ready=0, mul_enable=0, rsp fields stable; no beat lost or duplicated after release.
- Illegal fmt. Stimulus: fmt=7.
  - Response: rsp_err=1, rsp_y=0, mul_enable never high for that beat.
- Reset mid-burst. Stimulus: reset_n=0 for 1 cycle during req3's burst.
  - Response: rsp_valid=0 next cycle; FSM IDLE; the lowest-index valid requester (from pointer 0) is granted first.

Source files
------------

// File: rtl/tcu_drl_mul_sched.sv
// Round-robin burst scheduler for one shared drl multiplier slice.
// Optional perf counters: define TCU_MUL_SCHED_PERF_EN.
module tcu_drl_mul_sched #(
    parameter int NUM_REQS    = 4,
    parameter int MUL_LATENCY = 1,
    parameter int IDX_W       = 4,
    localparam int ID_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQS-1:0]     req_valid,
    output logic [NUM_REQS-1:0]     req_ready,
    input  logic [NUM_REQS-1:0]     req_last,
    input  logic [NUM_REQS*4-1:0]   req_fmt,
    input  logic [NUM_REQS*16-1:0]  req_a,
    input  logic [NUM_REQS*16-1:0]  req_b,
    input  logic [NUM_REQS-1:0]     req_exp_low_larger,
    input  logic [NUM_REQS*7-1:0]   req_raw_exp_diff,
    output logic                    mul_enable,
    output logic [3:0]              mul_fmt_s,
    output logic [15:0]             mul_a,
    output logic [15:0]             mul_b,
    output logic                    mul_exp_low_larger,
    output logic [6:0]              mul_raw_exp_diff,
    input  logic [24:0]             mul_y,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [24:0]             rsp_y,
    output logic [ID_W-1:0]         rsp_id,
    output logic [IDX_W-1:0]        rsp_idx,
    output logic                    rsp_last,
    output logic                    rsp_err
`ifdef TCU_MUL_SCHED_PERF_EN
    ,
    output logic [31:0]             perf_busy_cycles,
    output logic [31:0]             perf_stall_cycles
`endif
);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    typedef struct packed {
        logic             v;
        logic [ID_W-1:0]  id;
        logic [IDX_W-1:0] idx;
        logic             last;
        logic             err;
    } tag_t;

    state_t                   state_q, state_d;
    logic [ID_W-1:0]          owner_q, owner_d;
    logic [ID_W-1:0]          rr_q, rr_d;
    logic [IDX_W-1:0]         cnt_q, cnt_d;
    tag_t [MUL_LATENCY-1:0]   tag_q, tag_d;
    logic [3:0]               fmt_q, fmt_d;
    logic [15:0]              a_q, a_d;
    logic [15:0]              b_q, b_d;
    logic                     ell_q, ell_d;
    logic [6:0]               red_q, red_d;
    logic                     rv_q, rv_d;
    logic [24:0]              ry_q, ry_d;
    logic [ID_W-1:0]          rid_q, rid_d;
    logic [IDX_W-1:0]         ridx_q, ridx_d;
    logic                     rlast_q, rlast_d;
    logic                     rerr_q, rerr_d;

    logic                     stall;
    logic                     found;
    logic                     acc;
    logic [ID_W-1:0]          gnt_id;
    logic [IDX_W-1:0]         beat_idx;
    logic [3:0]               sel_fmt;
    logic                     sel_last;
    logic                     sel_legal;
    int                       j;

    assign stall = rv_q & ~rsp_ready;

    // Arbitration: rotate from the RR pointer when idle, owner only when locked
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        j      = 0;
        if (state_q == S_IDLE) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                j = int'(rr_q) + i;
                if (j >= NUM_REQS) j = j - NUM_REQS;
                if (!found && req_valid[j]) begin
                    found  = 1'b1;
                    gnt_id = ID_W'(j);
                end
            end
        end else if (req_valid[owner_q]) begin
            found  = 1'b1;
            gnt_id = owner_q;
        end
        acc       = found & ~stall & reset_n;
        req_ready = acc ? (NUM_REQS'(1) << gnt_id) : '0;
        sel_fmt   = req_fmt[gnt_id*4 +: 4];
        sel_last  = req_last[gnt_id];
        beat_idx  = (state_q == S_IDLE) ? '0 : cnt_q;
        case (sel_fmt)
            4'd1, 4'd2, 4'd3, 4'd4,
            4'd9, 4'd10, 4'd11, 4'd12: sel_legal = 1'b1;
            default:                   sel_legal = 1'b0;
        endcase
    end

    // Burst lock, RR pointer and beat counter next state
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        if (acc) begin
            if (sel_last) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                rr_d    = (int'(gnt_id) == NUM_REQS - 1) ? '0 : gnt_id + 1'b1;
            end else begin
                state_d = S_LOCKED;
                owner_d = gnt_id;
                cnt_d   = beat_idx + 1'b1;
            end
        end
    end

    // Issue register, tag pipeline and response register; all frozen on stall
    always_comb begin
        fmt_d   = fmt_q;
        a_d     = a_q;
        b_d     = b_q;
        ell_d   = ell_q;
        red_d   = red_q;
        tag_d   = tag_q;
        rv_d    = rv_q;
        ry_d    = ry_q;
        rid_d   = rid_q;
        ridx_d  = ridx_q;
        rlast_d = rlast_q;
        rerr_d  = rerr_q;
        if (!stall) begin
            rv_d = tag_q[MUL_LATENCY-1].v;
            if (tag_q[MUL_LATENCY-1].v) begin
                ry_d    = tag_q[MUL_LATENCY-1].err ? '0 : mul_y;
                rid_d   = tag_q[MUL_LATENCY-1].id;
                ridx_d  = tag_q[MUL_LATENCY-1].idx;
                rlast_d = tag_q[MUL_LATENCY-1].last;
                rerr_d  = tag_q[MUL_LATENCY-1].err;
            end
            for (int i = MUL_LATENCY - 1; i > 0; i--) begin
                tag_d[i] = tag_q[i-1];
            end
            tag_d[0] = '0;
            if (acc) begin
                tag_d[0] = '{v: 1'b1, id: gnt_id, idx: beat_idx,
                             last: sel_last, err: ~sel_legal};
                fmt_d = sel_fmt;
                a_d   = req_a[gnt_id*16 +: 16];
                b_d   = req_b[gnt_id*16 +: 16];
                ell_d = req_exp_low_larger[gnt_id];
                red_d = req_raw_exp_diff[gnt_id*7 +: 7];
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            tag_q   <= '0;
            fmt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ell_q   <= 1'b0;
            red_q   <= '0;
            rv_q    <= 1'b0;
            ry_q    <= '0;
            rid_q   <= '0;
            ridx_q  <= '0;
            rlast_q <= 1'b0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            fmt_q   <= fmt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ell_q   <= ell_d;
            red_q   <= red_d;
            rv_q    <= rv_d;
            ry_q    <= ry_d;
            rid_q   <= rid_d;
            ridx_q  <= ridx_d;
            rlast_q <= rlast_d;
            rerr_q  <= rerr_d;
        end
    end

    assign mul_enable         = tag_q[0].v & ~tag_q[0].err & ~stall & reset_n;
    assign mul_fmt_s          = fmt_q;
    assign mul_a              = a_q;
    assign mul_b              = b_q;
    assign mul_exp_low_larger = ell_q;
    assign mul_raw_exp_diff   = red_q;
    assign rsp_valid          = rv_q;
    assign rsp_y              = ry_q;
    assign rsp_id             = rid_q;
    assign rsp_idx            = ridx_q;
    assign rsp_last           = rlast_q;
    assign rsp_err            = rerr_q;

`ifdef TCU_MUL_SCHED_PERF_EN
    logic [31:0] busy_q, busy_d;
    logic [31:0] stl_q, stl_d;

    // Saturating activity counters
    always_comb begin
        busy_d = busy_q;
        stl_d  = stl_q;
        if (tag_q[0].v && !stall && busy_q != '1) busy_d = busy_q + 1'b1;
        if (stall && stl_q != '1) stl_d = stl_q + 1'b1;
    end

    // Counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_q <= '0;
            stl_q  <= '0;
        end else begin
            busy_q <= busy_d;
            stl_q  <= stl_d;
        end
    end

    assign perf_busy_cycles  = busy_q;
    assign perf_stall_cycles = stl_q;
`endif

endmodule

// File: tb/tb_tcu_drl_mul_sched.sv
// Randomized bench for tcu_drl_mul_sched against a queue-based
// transaction model of arbitration, burst locking and response timing.
module tb_tcu_drl_mul_sched;

    localparam int N   = 4;
    localparam int L   = 1;
    localparam int IW  = 4;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid, req_ready, req_last, req_exp_low_larger;
    logic [N*4-1:0]  req_fmt;
    logic [N*16-1:0] req_a, req_b;
    logic [N*7-1:0]  req_raw_exp_diff;
    logic            mul_enable, mul_exp_low_larger;
    logic [3:0]      mul_fmt_s;
    logic [15:0]     mul_a, mul_b;
    logic [6:0]      mul_raw_exp_diff;
    logic [24:0]     mul_y;
    logic            rsp_valid, rsp_ready, rsp_last, rsp_err;
    logic [24:0]     rsp_y;
    logic [IDW-1:0]  rsp_id;
    logic [IW-1:0]   rsp_idx;

    always #5 clk = ~clk;

    tcu_drl_mul_sched #(.NUM_REQS(N), .MUL_LATENCY(L), .IDX_W(IW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
        .req_fmt(req_fmt), .req_a(req_a), .req_b(req_b),
        .req_exp_low_larger(req_exp_low_larger),
        .req_raw_exp_diff(req_raw_exp_diff),
        .mul_enable(mul_enable), .mul_fmt_s(mul_fmt_s),
        .mul_a(mul_a), .mul_b(mul_b),
        .mul_exp_low_larger(mul_exp_low_larger),
        .mul_raw_exp_diff(mul_raw_exp_diff), .mul_y(mul_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
        .rsp_id(rsp_id), .rsp_idx(rsp_idx), .rsp_last(rsp_last),
        .rsp_err(rsp_err)
    );

    function automatic logic [24:0] slice_f(logic [15:0] a, logic [15:0] b,
                                            logic [3:0] f, logic el,
                                            logic [6:0] d);
        return {f[1:0], el, d[5:0], a ^ b};
    endfunction

    // single-cycle slice stand-in
    always_comb mul_y = slice_f(mul_a, mul_b, mul_fmt_s,
                                mul_exp_low_larger, mul_raw_exp_diff);

    typedef struct {
        logic [24:0] y;
        int          id;
        int          idx;
        bit          last;
        bit          err;
        int          age;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  fmt;
    } ent_t;

    ent_t q[$];
    ent_t rsp_e;
    bit   rv_e, locked, acc_e;
    int   ptr, owner, cnt, g_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal(logic [3:0] f);
        return f inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10, 4'd11, 4'd12};
    endfunction

    // model update for the clock edge that just occurred
    task automatic model_edge();
        ent_t e;
        if (!reset_n) begin
            q.delete();
            rv_e = 0; locked = 0; ptr = 0; owner = 0; cnt = 0;
            return;
        end
        if (rv_e && !rsp_ready) return;
        rv_e = 0;
        if (q.size() > 0 && q[0].age == L) begin
            rsp_e = q.pop_front();
            rv_e  = 1;
        end
        foreach (q[i]) q[i].age++;
        if (acc_e) begin
            e.id   = g_e;
            e.idx  = locked ? cnt : 0;
            e.last = req_last[g_e];
            e.fmt  = req_fmt[g_e*4 +: 4];
            e.err  = !legal(e.fmt);
            e.a    = req_a[g_e*16 +: 16];
            e.b    = req_b[g_e*16 +: 16];
            e.y    = e.err ? 25'd0 : slice_f(e.a, e.b, e.fmt,
                         req_exp_low_larger[g_e], req_raw_exp_diff[g_e*7 +: 7]);
            e.age  = 1;
            q.push_back(e);
            if (e.last) begin
                locked = 0; cnt = 0; ptr = (g_e + 1) % N;
            end else begin
                locked = 1; owner = g_e; cnt = (e.idx + 1) % (1 << IW);
            end
        end
    endtask

    // compare DUT outputs with the model for the current cycle
    task automatic check_cycle();
        bit   stall_e, found, has1;
        ent_t iss;
        stall_e = rv_e && !rsp_ready;
        found = 0; g_e = 0; has1 = 0;
        if (locked) begin
            if (req_valid[owner]) begin found = 1; g_e = owner; end
        end else begin
            for (int i = 0; i < N; i++)
                if (!found && req_valid[(ptr + i) % N]) begin
                    found = 1; g_e = (ptr + i) % N;
                end
        end
        acc_e = found && !stall_e && reset_n;
        check("req_ready", 32'(req_ready), acc_e ? 32'(1 << g_e) : 32'd0);
        foreach (q[i]) if (q[i].age == 1) begin has1 = 1; iss = q[i]; end
        check("mul_enable", 32'(mul_enable),
              32'(has1 && !iss.err && !stall_e && reset_n));
        if (has1) begin
            check("mul_a", 32'(mul_a), 32'(iss.a));
            check("mul_b", 32'(mul_b), 32'(iss.b));
            check("mul_fmt", 32'(mul_fmt_s), 32'(iss.fmt));
        end
        check("rsp_valid", 32'(rsp_valid), 32'(rv_e));
        if (rv_e) begin
            check("rsp_y", 32'(rsp_y), 32'(rsp_e.y));
            check("rsp_id", 32'(rsp_id), 32'(rsp_e.id));
            check("rsp_idx", 32'(rsp_idx), 32'(rsp_e.idx));
            check("rsp_last", 32'(rsp_last), 32'(rsp_e.last));
            check("rsp_err", 32'(rsp_err), 32'(rsp_e.err));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic settle_check();
        #1;
        check_cycle();
    endtask

    task automatic rand_in(int pv, int plast, int prdy, int pill);
        logic [3:0] lf [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10, 4'd11, 4'd12};
        for (int i = 0; i < N; i++) begin
            req_valid[i] = ($urandom % 100) < pv;
            req_last[i]  = ($urandom % 100) < plast;
            req_fmt[i*4 +: 4] = (($urandom % 100) < pill) ?
                                4'($urandom % 16) : lf[$urandom % 8];
            req_a[i*16 +: 16] = 16'($urandom);
            req_b[i*16 +: 16] = 16'($urandom);
            req_exp_low_larger[i] = 1'($urandom);
            req_raw_exp_diff[i*7 +: 7] = 7'($urandom);
        end
        rsp_ready = ($urandom % 100) < prdy;
    endtask

    task automatic idle_in();
        req_valid = '0; req_last = '0; req_fmt = '0;
        req_a = '0; req_b = '0;
        req_exp_low_larger = '0; req_raw_exp_diff = '0;
        rsp_ready = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_in();
        tick();
        tick();
        reset_n = 1'b1;
        settle_check();

        // single beat from requester 0
        tick();
        req_valid = 4'b0001; req_last = 4'b0001;
        req_fmt[3:0] = 4'd1; req_a[15:0] = 16'h3C00; req_b[15:0] = 16'h4000;
        settle_check();
        tick(); idle_in(); settle_check();
        tick(); settle_check();
        tick(); settle_check();

        // 3-beat burst on req1 with req2 waiting
        for (int k = 0; k < 5; k++) begin
            tick();
            rand_in(0, 0, 100, 0);
            req_valid = 4'b0110;
            req_last  = (k == 2) ? 4'b0110 : 4'b0100;
            settle_check();
        end
        tick(); idle_in(); settle_check();

        // all requesters streaming single-beat bursts
        for (int k = 0; k < 12; k++) begin
            tick(); rand_in(100, 100, 100, 0); settle_check();
        end

        // back-pressure window mid-stream
        for (int k = 0; k < 9; k++) begin
            tick(); rand_in(80, 40, 100, 0);
            if (k >= 2 && k < 7) rsp_ready = 1'b0;
            settle_check();
        end

        // illegal fmt beat
        tick(); idle_in();
        req_valid = 4'b1000; req_last = 4'b1000; req_fmt[15:12] = 4'd7;
        req_a[63:48] = 16'h1234;
        settle_check();
        tick(); idle_in(); settle_check();
        tick(); settle_check();

        // long random run with a reset mid-burst on req3
        for (int k = 0; k < 600; k++) begin
            tick();
            rand_in(60, 25, 75, 15);
            reset_n = 1'b1;
            if (k == 300) begin
                req_valid = 4'b1000; req_last = '0;
            end
            if (k == 302) reset_n = 1'b0;
            settle_check();
        end

        for (int k = 0; k < 6; k++) begin
            tick(); idle_in(); reset_n = 1'b1; settle_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
